fp_div_seq: RTL and testbench

- Multi-cycle, parametrised IEEE-754-style floating-point divider. It is the sequential successor to the team's combinational single-precision divider.
- It computes one restoring-division quotient bit per clock, then normalises and packs the result.
- It handles zero, infinity, NaN, overflow and underflow, and reports status flags.
- It sits in the FPU datapath behind the operation decoder and uses a start/done handshake, so the divide no longer sets the FPU critical path.

---
 rtl/fp_div_seq.sv | 96 +++++++++
 tb/tb_fp_div_seq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fp_div_seq.sv
// fp_div_seq: multi-cycle restoring floating-point divider with start/done handshake
module fp_div_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BIAS  = 127
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [EXP_W+MAN_W:0]     A,
    input  logic [EXP_W+MAN_W:0]     B,
    output logic                     busy,
    output logic                     done,
    output logic [EXP_W+MAN_W:0]     result,
    output logic                     div_by_zero,
    output logic                     invalid
);
    localparam int W  = EXP_W + MAN_W + 1;
    localparam int CW = $clog2(MAN_W + 2);
    typedef enum logic [2:0] {IDLE, LOAD, DIVIDE, NORM, DONE} state_t;
    typedef enum logic [1:0] {K_NORM, K_NAN, K_INF, K_ZERO} kind_t;
    state_t state, state_nx;
    kind_t kind;
    logic sa, sb, sign, dz;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb, frac_n;
    logic [EXP_W+1:0] exp_d, exp_n;
    logic [MAN_W+1:0] rem, q;
    logic [MAN_W+2:0] trial;
    logic [CW-1:0] cnt;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, is_nan, oflow, uflow;
    logic [W-1:0] res_n;
    assign busy   = state != IDLE;
    assign done   = state == DONE;
    assign a_zero = ea == '0;
    assign b_zero = eb == '0;
    assign a_inf  = &ea && fa == '0;
    assign b_inf  = &eb && fb == '0;
    assign a_nan  = &ea && fa != '0;
    assign b_nan  = &eb && fb != '0;
    assign is_nan = a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf);
    assign trial  = {1'b0, rem} - {2'b0, !b_zero, fb};
    assign frac_n = q[MAN_W+1] ? q[MAN_W:1] : q[MAN_W-1:0];
    assign exp_n  = q[MAN_W+1] ? exp_d : exp_d - (EXP_W+2)'(1);
    assign uflow  = exp_n[EXP_W+1] || exp_n == '0;
    assign oflow  = !exp_n[EXP_W+1] && exp_n[EXP_W:0] >= (EXP_W+1)'((1 << EXP_W) - 1);
    assign res_n  = kind == K_NAN ? {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}} :
                    (kind == K_INF || (kind == K_NORM && oflow)) ? {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                    (kind == K_ZERO || uflow) ? {sign, {(W-1){1'b0}}} :
                    {sign, exp_n[EXP_W-1:0], frac_n};
    always_comb begin
        state_nx = state == IDLE   ? (start ? LOAD : IDLE) :
                   state == LOAD   ? DIVIDE :
                   state == DIVIDE ? (cnt == CW'(MAN_W + 1) ? NORM : DIVIDE) :
                   state == NORM   ? DONE : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            result      <= '0;
            div_by_zero <= 1'b0;
            invalid     <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                sa          <= A[W-1];
                sb          <= B[W-1];
                ea          <= A[W-2:MAN_W];
                eb          <= B[W-2:MAN_W];
                fa          <= A[W-2:MAN_W] == '0 ? '0 : A[MAN_W-1:0];
                fb          <= B[W-2:MAN_W] == '0 ? '0 : B[MAN_W-1:0];
                div_by_zero <= 1'b0;
                invalid     <= 1'b0;
            end
            if (state == LOAD) begin
                sign  <= sa ^ sb;
                exp_d <= {2'b0, ea} - {2'b0, eb} + (EXP_W+2)'(BIAS);
                kind  <= is_nan ? K_NAN : (b_zero || a_inf) ? K_INF : (a_zero || b_inf) ? K_ZERO : K_NORM;
                dz    <= !is_nan && b_zero && !a_inf;
                rem   <= {1'b0, !a_zero, fa};
                q     <= '0;
                cnt   <= '0;
            end
            if (state == DIVIDE) begin
                q   <= {q[MAN_W:0], !trial[MAN_W+2]};
                rem <= {trial[MAN_W+2] ? rem[MAN_W:0] : trial[MAN_W:0], 1'b0};
                cnt <= cnt + 1'b1;
            end
            if (state == NORM) begin
                result      <= res_n;
                invalid     <= kind == K_NAN;
                div_by_zero <= dz;
            end
        end
    end
endmodule

// File: tb/tb_fp_div_seq.sv
// tb_fp_div_seq: scoreboard bench for fp_div_seq against an arithmetic reference model
module tb_fp_div_seq;
    typedef struct {
        logic [31:0] r;
        logic        dz;
        logic        inv;
        int          acc;
    } exp_t;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [31:0] A = '0, B = '0;
    logic busy, done, div_by_zero, invalid;
    logic [31:0] result;
    exp_t sb_q[$];
    exp_t got;
    int cyc = 0, n_cmp = 0, n_bad = 0;

    fp_div_seq dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .result(result),
        .div_by_zero(div_by_zero), .invalid(invalid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b);
        logic s;
        int ea, eb, e;
        longint fa, fb, ma, mb, q;
        bit az, bz, ai, bi, an, bn;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = ea == 0 ? 0 : longint'(a[22:0]);
        fb = eb == 0 ? 0 : longint'(b[22:0]);
        az = ea == 0;
        bz = eb == 0;
        ai = ea == 255 && fa == 0;
        bi = eb == 255 && fb == 0;
        an = ea == 255 && fa != 0;
        bn = eb == 255 && fb != 0;
        if (an || bn || (az && bz) || (ai && bi)) return {1'b1, 1'b0, 32'h7FC00000};
        if (bz) return {1'b0, !ai, s, 8'hFF, 23'h0};
        if (ai) return {2'b00, s, 8'hFF, 23'h0};
        if (az || bi) return {2'b00, s, 31'h0};
        ma = fa + (64'd1 << 23);
        mb = fb + (64'd1 << 23);
        e = ea - eb + 127;
        if (ma >= mb) q = (ma << 23) / mb;
        else begin
            q = (ma << 24) / mb;
            e = e - 1;
        end
        if (e >= 255) return {2'b00, s, 8'hFF, 23'h0};
        if (e <= 0) return {2'b00, s, 31'h0};
        return {2'b00, s, e[7:0], q[22:0]};
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit push);
        logic [33:0] m;
        exp_t x;
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("issue_timeout", 32'(busy), 32'd0);
        m = model(a, b);
        x.r = m[31:0];
        x.dz = m[32];
        x.inv = m[33];
        x.acc = cyc + 1;
        if (push) sb_q.push_back(x);
        A = a;
        B = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = $urandom;
        B = $urandom;
        chk("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 32'(done), 32'd1);
    endtask

    function automatic logic [31:0] rnd_op();
        logic [7:0] e;
        logic [22:0] f;
        int k = $urandom_range(0, 9);
        e = k == 0 ? 8'd0 : k == 1 ? 8'hFF : k == 2 ? 8'd1 : k == 3 ? 8'hFE : 8'($urandom);
        f = $urandom_range(0, 5) == 0 ? 23'd0 : 23'($urandom);
        return {1'($urandom), e, f};
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
            else begin
                got = sb_q.pop_front();
                chk("result", result, got.r);
                chk("div_by_zero", 32'(div_by_zero), 32'(got.dz));
                chk("invalid", 32'(invalid), 32'(got.inv));
                chk("latency", 32'(cyc - got.acc), 32'd27);
                chk("busy_at_done", 32'(busy), 32'd1);
            end
        end
    end

    logic [31:0] dir_a[10] = '{32'h3F800000, 32'hC0C00000, 32'hBF800000, 32'h00000000, 32'h7F800000,
                              32'h3F800000, 32'h7F000000, 32'h00800000, 32'h00400000, 32'h7FC00001};
    logic [31:0] dir_b[10] = '{32'h40400000, 32'h40000000, 32'h00000000, 32'h00000000, 32'h3F800000,
                              32'h7F800000, 32'h00800000, 32'h7F000000, 32'h3F800000, 32'h3F800000};

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {30'd0, div_by_zero, invalid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("model_6_2", model(32'h40C00000, 32'h40000000), {2'b00, 32'h40400000});
        chk("model_1_3", model(32'h3F800000, 32'h40400000), {2'b00, 32'h3EAAAAAA});
        issue(32'h40C00000, 32'h40000000, 1'b1);
        wait_done();
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        chk("result_hold", result, 32'h40400000);
        chk("busy_after_done", 32'(busy), 32'd0);
        for (int i = 0; i < 10; i++) issue(dir_a[i], dir_b[i], 1'b1);
        issue(32'h40C00000, 32'h40000000, 1'b1);
        repeat (4) @(negedge clk);
        A = 32'h3F800000;
        B = 32'h40400000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        @(negedge clk);
        issue(32'h3F800000, 32'h3F800000, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_flags", {30'd0, div_by_zero, invalid}, 32'd0);
        repeat (40) @(negedge clk);
        for (int i = 0; i < 200; i++) issue(rnd_op(), rnd_op(), 1'b1);
        wait_done();
        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
